// File: rtl/umi_rr_arbiter.sv
// N-to-1 UMI request arbiter with round-robin or fixed-priority selection,
// per-requester disable mask and a single registered output stage.
module umi_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*256-1:0] in_packet,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             arb_mode,
    input  logic [N-1:0]     req_mask,
    output logic [255:0]     out_packet,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDW-1:0]   out_id
);

    logic [N-1:0]   elig;
    logic           free;
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] ptr;
    logic [255:0]   win_packet;

    assign elig = in_valid & ~req_mask;
    assign free = !out_valid || out_ready;

    // Round-robin scans indices above the pointer first, then wraps to 0..ptr;
    // fixed priority is just the wrapped pass without the pointer bound.
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (!arb_mode) begin
            for (int k = 0; k < N; k++) begin
                if (!found && elig[k] && (IDW'(k) > ptr)) begin
                    found = 1'b1;
                    win   = IDW'(k);
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && elig[k] && (arb_mode || (IDW'(k) <= ptr))) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end

    always_comb begin
        win_packet = '0;
        for (int k = 0; k < N; k++) begin
            if (win == IDW'(k)) begin
                win_packet = in_packet[k*256 +: 256];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && free && found) begin
            for (int k = 0; k < N; k++) begin
                if (win == IDW'(k)) begin
                    in_ready[k] = 1'b1;
                end
            end
        end
    end

    // Pointer resets to N-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_packet <= '0;
            out_id     <= '0;
            ptr        <= IDW'(N - 1);
        end else if (free) begin
            if (found) begin
                out_valid  <= 1'b1;
                out_packet <= win_packet;
                out_id     <= win;
                ptr        <= win;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
